layer_reset_hold_ctrl: RTL and testbench

Parametrised per-layer reset, hold and interrupt controller between the layer register file and the board pins. It generalises the fixed 20-row, 4-rows-per-reset-line OR wiring into NUM_LAYERS layers with configurable group size. Each shared reset line is driven by a timed pulse/recovery sequencer rather than a plain OR. Hold is generated automatically from synchronised interrupts, and interrupts are masked while a group is resetting.

---
 rtl/layer_reset_hold_ctrl_pkg.sv | 30 +++
 rtl/layer_reset_hold_ctrl_group_seq.sv | 84 ++++++++
 rtl/layer_reset_hold_ctrl.sv | 110 +++++++++++
 tb/tb_layer_reset_hold_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/layer_reset_hold_ctrl_pkg.sv
// rtl/layer_reset_hold_ctrl_pkg.sv - shared types and sizing helpers for the layer reset/hold controller
package layer_ctrl_pkg;

  // Per-group sequencer states; IDLE is the all-zero reset encoding.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PULSE   = 2'd1,
    RECOVER = 2'd2
  } grp_state_t;

  // Number of board reset lines needed to cover n layers in groups of g.
  function automatic int num_groups(input int n, input int g);
    return (n + g - 1) / g;
  endfunction

  // Board reset line that owns a given layer.
  function automatic int group_of(input int layer, input int g);
    return layer / g;
  endfunction

  // Counter width able to hold the longer of the pulse and recovery loads.
  function automatic int cnt_width(input int pulse_cycles, input int recovery_cycles);
    int m;
    int w;
    m = (pulse_cycles > recovery_cycles) ? pulse_cycles : recovery_cycles;
    w = $clog2(m + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/layer_reset_hold_ctrl_group_seq.sv
// rtl/layer_reset_hold_ctrl_group_seq.sv - timed pulse/recovery sequencer for one shared reset line
module layer_group_reset_seq
  import layer_ctrl_pkg::*;
#(
  parameter int RESET_PULSE_CYCLES    = 100,
  parameter int RESET_RECOVERY_CYCLES = 50
) (
  input  logic sysclk,
  input  logic warm_rst,
  input  logic i_req,
  output logic o_group_reset,
  output logic o_busy,
  output logic o_done,
  output logic o_pulse_start
);

  localparam int CW = cnt_width(RESET_PULSE_CYCLES, RESET_RECOVERY_CYCLES);
  localparam logic [CW-1:0] LOAD_PULSE = CW'(RESET_PULSE_CYCLES - 1);
  localparam logic [CW-1:0] LOAD_RECOVER =
    CW'((RESET_RECOVERY_CYCLES > 0) ? (RESET_RECOVERY_CYCLES - 1) : 0);
  localparam bit HAS_RECOVER = (RESET_RECOVERY_CYCLES > 0);

  grp_state_t    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_done;
  logic          w_cnt_term;

  // The counter holds "cycles left after this one", so zero marks the last cycle of a phase.
  assign w_cnt_term = (r_cnt == '0);

  // Phase sequencing: a request always (re)starts a full-length pulse; the counter never wraps.
  always_ff @(posedge sysclk) begin
    if (warm_rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_req) begin
            r_state <= PULSE;
            r_cnt   <= LOAD_PULSE;
          end
        end
        PULSE: begin
          if (i_req) begin
            r_cnt <= LOAD_PULSE;
          end else if (!w_cnt_term) begin
            r_cnt <= r_cnt - CW'(1);
          end else if (HAS_RECOVER) begin
            r_state <= RECOVER;
            r_cnt   <= LOAD_RECOVER;
          end else begin
            r_state <= IDLE;
            r_done  <= 1'b1;
          end
        end
        RECOVER: begin
          if (i_req) begin
            r_state <= PULSE;
            r_cnt   <= LOAD_PULSE;
          end else if (!w_cnt_term) begin
            r_cnt <= r_cnt - CW'(1);
          end else begin
            r_state <= IDLE;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign o_group_reset = (r_state == PULSE);
  assign o_busy        = (r_state != IDLE);
  assign o_done        = r_done;
  // High on the cycle whose clock edge moves the group into PULSE (not on in-pulse reloads).
  assign o_pulse_start = i_req && (r_state != PULSE);

endmodule

// File: rtl/layer_reset_hold_ctrl.sv
// rtl/layer_reset_hold_ctrl.sv - per-layer reset grouping, interrupt sync/masking and hold generation
module layer_reset_hold_ctrl
  import layer_ctrl_pkg::*;
#(
  parameter int NUM_LAYERS            = 20,
  parameter int LAYERS_PER_GROUP      = 4,
  parameter int RESET_PULSE_CYCLES    = 100,
  parameter int RESET_RECOVERY_CYCLES = 50,
  parameter int INT_SYNC_STAGES       = 2,
  localparam int NUM_GROUPS = num_groups(NUM_LAYERS, LAYERS_PER_GROUP)
) (
  input  logic                  sysclk,
  input  logic                  warm_rst,
  input  logic [NUM_LAYERS-1:0] layer_reset_req,
  input  logic [NUM_LAYERS-1:0] layer_hold_force,
  input  logic [NUM_LAYERS-1:0] layer_hold_auto_en,
  input  logic [NUM_LAYERS-1:0] layer_hold_release,
  input  logic [NUM_LAYERS-1:0] layer_interruptn,
  output logic [NUM_GROUPS-1:0] group_reset,
  output logic [NUM_LAYERS-1:0] layer_hold,
  output logic [NUM_LAYERS-1:0] layer_int,
  output logic [NUM_GROUPS-1:0] group_busy,
  output logic [NUM_GROUPS-1:0] group_done
);

  logic [NUM_GROUPS-1:0] w_grp_req;
  logic [NUM_GROUPS-1:0] w_grp_pulse;
  logic [NUM_GROUPS-1:0] w_grp_busy;
  logic [NUM_GROUPS-1:0] w_grp_done;
  logic [NUM_GROUPS-1:0] w_grp_start;

  logic [NUM_LAYERS-1:0] w_lay_busy;
  logic [NUM_LAYERS-1:0] w_lay_pulse;
  logic [NUM_LAYERS-1:0] w_lay_start;
  logic [NUM_LAYERS-1:0] w_int_s;
  logic [NUM_LAYERS-1:0] w_latch_nxt;

  logic [INT_SYNC_STAGES-1:0] r_sync [NUM_LAYERS];
  logic [NUM_LAYERS-1:0]      r_latch;
  logic [NUM_LAYERS-1:0]      r_int;
  logic [NUM_LAYERS-1:0]      r_hold;

  // One sequencer per board reset line; the last group's slice is clipped to the layers that exist.
  for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_grp
    localparam int LO = g * LAYERS_PER_GROUP;
    localparam int HI = ((LO + LAYERS_PER_GROUP) < NUM_LAYERS) ?
                        (LO + LAYERS_PER_GROUP - 1) : (NUM_LAYERS - 1);

    assign w_grp_req[g] = |layer_reset_req[HI:LO];

    layer_group_reset_seq #(
      .RESET_PULSE_CYCLES    (RESET_PULSE_CYCLES),
      .RESET_RECOVERY_CYCLES (RESET_RECOVERY_CYCLES)
    ) u_seq (
      .sysclk        (sysclk),
      .warm_rst      (warm_rst),
      .i_req         (w_grp_req[g]),
      .o_group_reset (w_grp_pulse[g]),
      .o_busy        (w_grp_busy[g]),
      .o_done        (w_grp_done[g]),
      .o_pulse_start (w_grp_start[g])
    );
  end

  // Fan each group's status back out to its member layers.
  for (genvar k = 0; k < NUM_LAYERS; k++) begin : g_lay
    localparam int G = group_of(k, LAYERS_PER_GROUP);
    assign w_lay_busy[k]  = w_grp_busy[G];
    assign w_lay_pulse[k] = w_grp_pulse[G];
    assign w_lay_start[k] = w_grp_start[G];
    assign w_int_s[k]     = ~r_sync[k][INT_SYNC_STAGES-1];
  end

  // Metastability chains for the asynchronous active-low interrupt pins; reset to "not interrupting".
  always_ff @(posedge sysclk) begin
    for (int k = 0; k < NUM_LAYERS; k++) begin
      if (warm_rst) begin
        r_sync[k] <= '1;
      end else begin
        r_sync[k] <= {r_sync[k][INT_SYNC_STAGES-2:0], layer_interruptn[k]};
      end
    end
  end

  // Auto-hold latch: release or a group entering PULSE clears it and beats a simultaneous set.
  always_comb begin
    w_latch_nxt = ~(layer_hold_release | w_lay_start) &
                  (r_latch | (layer_hold_auto_en & r_int));
  end

  // Masked interrupt, latch state and hold pins, all registered toward the board.
  always_ff @(posedge sysclk) begin
    if (warm_rst) begin
      r_latch <= '0;
      r_int   <= '0;
      r_hold  <= '0;
    end else begin
      r_latch <= w_latch_nxt;
      r_int   <= w_int_s & ~w_lay_busy;
      r_hold  <= w_latch_nxt | layer_hold_force | w_lay_pulse;
    end
  end

  assign group_reset = w_grp_pulse;
  assign group_busy  = w_grp_busy;
  assign group_done  = w_grp_done;
  assign layer_int   = r_int;
  assign layer_hold  = r_hold;

endmodule

// File: tb/tb_layer_reset_hold_ctrl.sv
// tb/tb_layer_reset_hold_ctrl.sv - self-checking bench with timestamp reference model and directed checks
module tb_layer_reset_hold_ctrl;

  localparam int NL  = 20;
  localparam int LPG = 4;
  localparam int P   = 100;
  localparam int R   = 50;
  localparam int S   = 2;
  localparam int NG  = (NL + LPG - 1) / LPG;
  localparam int NL2 = 10;
  localparam int NG2 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          warm_rst;
  logic [NL-1:0] req, hforce, hen, hrel, pinn;
  logic [NG-1:0] grst, gbusy, gdone;
  logic [NL-1:0] lhold, lint;

  logic [NL2-1:0] req2, pin2, zero2;
  logic [NG2-1:0] grst2, gbusy2, gdone2;
  logic [NL2-1:0] lhold2, lint2;

  layer_reset_hold_ctrl #(
    .NUM_LAYERS(NL), .LAYERS_PER_GROUP(LPG), .RESET_PULSE_CYCLES(P),
    .RESET_RECOVERY_CYCLES(R), .INT_SYNC_STAGES(S)
  ) dut (
    .sysclk(clk), .warm_rst(warm_rst), .layer_reset_req(req),
    .layer_hold_force(hforce), .layer_hold_auto_en(hen),
    .layer_hold_release(hrel), .layer_interruptn(pinn),
    .group_reset(grst), .layer_hold(lhold), .layer_int(lint),
    .group_busy(gbusy), .group_done(gdone)
  );

  layer_reset_hold_ctrl #(
    .NUM_LAYERS(NL2), .LAYERS_PER_GROUP(LPG), .RESET_PULSE_CYCLES(P),
    .RESET_RECOVERY_CYCLES(0), .INT_SYNC_STAGES(S)
  ) dut2 (
    .sysclk(clk), .warm_rst(warm_rst), .layer_reset_req(req2),
    .layer_hold_force(zero2), .layer_hold_auto_en(zero2),
    .layer_hold_release(zero2), .layer_interruptn(pin2),
    .group_reset(grst2), .layer_hold(lhold2), .layer_int(lint2),
    .group_busy(gbusy2), .group_done(gdone2)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference model: each group is described by the time window of its pulse and recovery.
  int ps [NG];
  int pe [NG];
  int re [NG];
  int da [NG];
  logic [NL-1:0] m_int, m_latch, m_hold;
  logic [S-1:0]  hist [NL];

  task automatic model_reset();
    for (int g = 0; g < NG; g++) begin
      ps[g] = 0; pe[g] = -1; re[g] = -1; da[g] = -1;
    end
    m_int = '0; m_latch = '0; m_hold = '0;
    for (int k = 0; k < NL; k++) hist[k] = '1;
  endtask

  logic [NG-1:0] e_rst, e_busy, e_done, greq;

  task automatic model_step(input int c);
    logic new_int;
    int g;
    greq = '0;
    for (int k = 0; k < NL; k++) greq[k / LPG] = greq[k / LPG] | req[k];
    for (int k = 0; k < NL; k++) begin
      g = k / LPG;
      new_int = ~hist[k][S-1] & ~e_busy[g];
      if (hrel[k] || (greq[g] && !e_rst[g])) m_latch[k] = 1'b0;
      else if (hen[k] && m_int[k])           m_latch[k] = 1'b1;
      m_hold[k] = m_latch[k] | hforce[k] | e_rst[g];
      m_int[k]  = new_int;
      hist[k]   = {hist[k][S-2:0], pinn[k]};
    end
    for (int gg = 0; gg < NG; gg++) begin
      if (greq[gg]) begin
        ps[gg] = c + 1; pe[gg] = c + P; re[gg] = c + P + R; da[gg] = c + P + R + 1;
      end
    end
  endtask

  // Event logs used by the directed literal checks.
  int rise_cyc [NG];
  int fall_cyc [NG];
  int busy_fall[NG];
  int done_cyc [NG];
  int rise_cnt [NG];
  int done_cnt [NG];
  int int_rise [NL];
  int hold_rise[NL];
  int hold_fall[NL];
  logic [NG-1:0] p_grst, p_gbusy;
  logic [NL-1:0] p_lint, p_lhold;

  // Per-cycle compare of every DUT output against the model, then advance the model.
  always @(negedge clk) begin
    if (cyc >= 1) begin
      for (int g = 0; g < NG; g++) begin
        e_rst[g]  = (cyc >= ps[g]) && (cyc <= pe[g]);
        e_busy[g] = (cyc >= ps[g]) && (cyc <= re[g]);
        e_done[g] = (cyc == da[g]);
      end
      chk("group_reset", 64'(grst), 64'(e_rst));
      chk("group_busy", 64'(gbusy), 64'(e_busy));
      chk("group_done", 64'(gdone), 64'(e_done));
      chk("layer_int", 64'(lint), 64'(m_int));
      chk("layer_hold", 64'(lhold), 64'(m_hold));

      for (int g = 0; g < NG; g++) begin
        if (grst[g] && !p_grst[g]) begin rise_cyc[g] = cyc; rise_cnt[g]++; end
        if (!grst[g] && p_grst[g]) fall_cyc[g] = cyc;
        if (!gbusy[g] && p_gbusy[g]) busy_fall[g] = cyc;
        if (gdone[g]) begin done_cyc[g] = cyc; done_cnt[g]++; end
      end
      for (int k = 0; k < NL; k++) begin
        if (lint[k] && !p_lint[k]) int_rise[k] = cyc;
        if (lhold[k] && !p_lhold[k]) hold_rise[k] = cyc;
        if (!lhold[k] && p_lhold[k]) hold_fall[k] = cyc;
      end
      p_grst = grst; p_gbusy = gbusy; p_lint = lint; p_lhold = lhold;

      if (warm_rst) model_reset();
      else model_step(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    req  = '0;
    hrel = '0;
    req2 = '0;
  endtask

  int t, t2, dc;
  int first2, cnt2, done2, busy2, other2;
  int rk;

  initial begin
    model_reset();
    for (int g = 0; g < NG; g++) begin
      rise_cyc[g] = -1; fall_cyc[g] = -1; busy_fall[g] = -1; done_cyc[g] = -1;
      rise_cnt[g] = 0; done_cnt[g] = 0;
    end
    for (int k = 0; k < NL; k++) begin
      int_rise[k] = -1; hold_rise[k] = -1; hold_fall[k] = -1;
    end
    p_grst = '0; p_gbusy = '0; p_lint = '0; p_lhold = '0;
    warm_rst = 1'b1;
    req = '0; hforce = '0; hen = '0; hrel = '0; pinn = '1;
    req2 = '0; pin2 = '1; zero2 = '0;
    repeat (3) tick();
    warm_rst = 1'b0;
    @(negedge clk);
    chk("rst_group_reset", 64'(grst), 64'd0);
    chk("rst_group_busy", 64'(gbusy), 64'd0);
    chk("rst_layer_hold", 64'(lhold), 64'd0);
    chk("rst_layer_int", 64'(lint), 64'd0);
    chk("rst_group_done", 64'(gdone), 64'd0);
    tick();

    // Single request on layer 5 (group 1).
    t = cyc; req[5] = 1'b1; tick();
    repeat (170) tick();
    chk("t1_rise", 64'(rise_cyc[1]), 64'(t + 1));
    chk("t1_fall", 64'(fall_cyc[1]), 64'(t + 101));
    chk("t1_busy_fall", 64'(busy_fall[1]), 64'(t + 151));
    chk("t1_done", 64'(done_cyc[1]), 64'(t + 151));
    chk("t1_other_groups", 64'(rise_cnt[0] + rise_cnt[2] + rise_cnt[3] + rise_cnt[4]), 64'd0);

    // Layers 0 and 3 together, then layer 2 at pulse cycle 60.
    t = cyc; req[0] = 1'b1; req[3] = 1'b1; tick();
    repeat (59) tick();
    req[2] = 1'b1; tick();
    repeat (230) tick();
    chk("t2_single_pulse", 64'(rise_cnt[0]), 64'd1);
    chk("t2_rise", 64'(rise_cyc[0]), 64'(t + 1));
    chk("t2_fall", 64'(fall_cyc[0]), 64'(t + 161));
    chk("t2_done", 64'(done_cyc[0]), 64'(t + 211));

    // Request during recovery cycle 20 of group 3.
    t = cyc; req[12] = 1'b1; tick();
    repeat (119) tick();
    req[13] = 1'b1; tick();
    repeat (200) tick();
    chk("t3_repulse", 64'(rise_cyc[3]), 64'(t + 121));
    chk("t3_done_count", 64'(done_cnt[3]), 64'd1);
    chk("t3_done", 64'(done_cyc[3]), 64'(t + 271));

    // Auto hold on layer 7.
    hen[7] = 1'b1; tick();
    t = cyc; pinn[7] = 1'b0;
    repeat (5) tick();
    pinn[7] = 1'b1;
    repeat (20) tick();
    chk("t4_int_rise", 64'(int_rise[7]), 64'(t + 3));
    chk("t4_hold_rise", 64'(hold_rise[7]), 64'(t + 4));
    @(negedge clk);
    chk("t4_hold_kept", 64'(lhold[7]), 64'd1);
    tick();
    t2 = cyc; hrel[7] = 1'b1; tick();
    repeat (3) tick();
    chk("t4_hold_fall", 64'(hold_fall[7]), 64'(t2 + 1));
    hen[7] = 1'b0;

    // Interrupt on layer 9 masked while group 2 is busy.
    hen[9] = 1'b1;
    t = cyc; req[10] = 1'b1; tick();
    repeat (4) tick();
    pinn[9] = 1'b0;
    repeat (110) tick();
    @(negedge clk);
    chk("t5_int_masked", 64'(lint[9]), 64'd0);
    chk("t5_no_latch", 64'(lhold[9]), 64'd0);
    tick();
    repeat (50) tick();
    chk("t5_busy_fall", 64'(busy_fall[2]), 64'(t + 151));
    chk("t5_int_rise", 64'(int_rise[9]), 64'(t + 152));
    chk("t5_hold_rise", 64'(hold_rise[9]), 64'(t + 153));
    pinn[9] = 1'b1; hrel[9] = 1'b1; hen[9] = 1'b0; tick();
    repeat (5) tick();

    // warm_rst at pulse cycle 40 aborts without a done pulse.
    t = cyc; req[9] = 1'b1; tick();
    repeat (39) tick();
    warm_rst = 1'b1; dc = done_cnt[2]; tick();
    warm_rst = 1'b0;
    @(negedge clk);
    chk("t5_abort_reset_low", 64'(grst[2]), 64'd0);
    chk("t5_abort_busy_low", 64'(gbusy[2]), 64'd0);
    tick();
    repeat (200) tick();
    chk("t5_abort_no_done", 64'(done_cnt[2]), 64'(dc));

    // Partial last group with no recovery on the second instance.
    t = cyc; req2[9] = 1'b1; tick();
    first2 = -1; cnt2 = 0; done2 = -1; busy2 = 0; other2 = 0;
    for (int i = 0; i < 110; i++) begin
      @(negedge clk);
      if (grst2[2]) begin
        if (first2 < 0) first2 = cyc - t;
        cnt2++;
      end
      if (gbusy2[2]) busy2++;
      if (gdone2[2]) done2 = cyc - t;
      if (grst2[0] || grst2[1] || gbusy2[0] || gbusy2[1]) other2++;
    end
    chk("t6_first_high", 64'(first2), 64'd1);
    chk("t6_high_cycles", 64'(cnt2), 64'd100);
    chk("t6_busy_cycles", 64'(busy2), 64'd100);
    chk("t6_done", 64'(done2), 64'd101);
    chk("t6_other_groups", 64'(other2), 64'd0);
    tick();
    repeat (5) tick();
    chk("t6_int_idle", 64'(lint2), 64'd0);
    chk("t6_hold_idle", 64'(lhold2), 64'd0);

    // Randomised traffic, checked cycle by cycle against the model.
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 99) < 2) begin
        rk = $urandom_range(0, NL - 1); req[rk] = 1'b1;
      end
      if ($urandom_range(0, 9) == 0) begin
        rk = $urandom_range(0, NL - 1); pinn[rk] = ~pinn[rk];
      end
      if ($urandom_range(0, 29) == 0) begin
        rk = $urandom_range(0, NL - 1); hrel[rk] = 1'b1;
      end
      if ($urandom_range(0, 199) == 0) begin
        rk = $urandom_range(0, NL - 1); hforce[rk] = ~hforce[rk];
      end
      if ($urandom_range(0, 49) == 0) begin
        rk = $urandom_range(0, NL - 1); hen[rk] = ~hen[rk];
      end
      warm_rst = ($urandom_range(0, 1999) == 0);
      tick();
    end
    warm_rst = 1'b0;
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
